// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with per-slot dead time and frame-wide input snapshots.
// Optional blink support is built when SEG_SCAN_BLINK_EN is defined; otherwise blink_mask_i is ignored.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 125000,
  parameter int DEAD         = 1250,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] digits_i,
  input  logic [3:0]  blank_mask_i,
  input  logic [3:0]  blink_mask_i,
  output logic [3:0]  en_o,
  output logic [6:0]  m_disp_o,
  output logic        frame_tick_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   s_dig_q, s_dig_d;
  logic [3:0]    s_blank_q, s_blank_d;
  logic          frame_end, snap, dark_d;
  logic [3:0]    en_d;
  logic [6:0]    m_disp_d;
  logic          tick_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    frame_end = (idx_q == 2'd3) && (cnt_q == CNT_MAX);
    snap      = (idx_q == 2'd0) && (cnt_q == '0);
    cnt_d     = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d     = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
    s_dig_d   = snap ? digits_i : s_dig_q;
    s_blank_d = snap ? blank_mask_i : s_blank_q;
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          ph_q, ph_d;
  logic [3:0]    s_blink_q, s_blink_d;

  always_comb begin
    fcnt_d = fcnt_q;
    ph_d   = ph_q;
    if (frame_end) begin
      if (fcnt_q == FCNT_MAX) begin
        fcnt_d = '0;
        ph_d   = ~ph_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    s_blink_d = snap ? blink_mask_i : s_blink_q;
    dark_d    = s_blank_d[idx_d] | (s_blink_d[idx_d] & ph_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fcnt_q    <= '0;
      ph_q      <= 1'b0;
      s_blink_q <= '0;
    end else begin
      fcnt_q    <= fcnt_d;
      ph_q      <= ph_d;
      s_blink_q <= s_blink_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask_i;

  always_comb dark_d = s_blank_d[idx_d];
`endif

  // Outputs are decoded from next state so the registered value matches the current state.
  always_comb begin
    en_d     = '0;
    m_disp_d = '0;
    if ((cnt_d >= DEAD_C) && !dark_d) begin
      en_d     = 4'b0001 << idx_d;
      m_disp_d = hex7(s_dig_d[{idx_d, 2'b00} +: 4]);
    end
    tick_d = (idx_d == 2'd3) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      s_dig_q      <= '0;
      s_blank_q    <= '0;
      en_o         <= '0;
      m_disp_o     <= '0;
      frame_tick_o <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      s_dig_q      <= s_dig_d;
      s_blank_q    <= s_blank_d;
      en_o         <= en_d;
      m_disp_o     <= m_disp_d;
      frame_tick_o <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  blank_mask = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic [3:0]  en;
  logic [6:0]  m_disp;
  logic        frame_tick;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int frame_no  = 0;

`ifdef SEG_SCAN_BLINK_EN
  localparam logic [3:0] BL_EN  = 4'b0000;
  localparam logic [6:0] BL_SEG = 7'h00;
`else
  localparam logic [3:0] BL_EN  = 4'b0001;
  localparam logic [6:0] BL_SEG = 7'h5E;
`endif

  seg_scan_ctrl #(.SCAN_DIV(8), .DEAD(2), .BLINK_FRAMES(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .digits_i     (digits),
    .blank_mask_i (blank_mask),
    .blink_mask_i (blink_mask),
    .en_o         (en),
    .m_disp_o     (m_disp),
    .frame_tick_o (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Starts sampling at cycle 0 of a slot; returns positioned at the sample after the last checked cycle.
  task automatic run_slot(input int k, input logic [3:0] e, input logic [6:0] s, input int ncyc = 8);
    for (int c = 0; c < ncyc; c++) begin
      chk($sformatf("f%0d_s%0d_c%0d_en", frame_no, k, c), {4'b0, en}, (c < 2) ? 8'h00 : {4'b0, e});
      chk($sformatf("f%0d_s%0d_c%0d_seg", frame_no, k, c), {1'b0, m_disp}, (c < 2) ? 8'h00 : {1'b0, s});
      chk($sformatf("f%0d_s%0d_c%0d_tick", frame_no, k, c), {7'b0, frame_tick}, {7'b0, (k == 3) && (c == 7)});
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en", {4'b0, en}, 8'h00);
    chk("rst_seg", {1'b0, m_disp}, 8'h00);
    chk("rst_tick", {7'b0, frame_tick}, 8'h00);
    rst = 1'b0;

    // Frame 0: digits change during slot 1 must not tear the frame.
    frame_no = 0;
    run_slot(0, 4'b0001, 7'h66);
    digits = 16'hABCD;
    run_slot(1, 4'b0010, 7'h4F);
    run_slot(2, 4'b0100, 7'h5B);
    run_slot(3, 4'b1000, 7'h06);

    frame_no = 1;
    run_slot(0, 4'b0001, 7'h5E);
    run_slot(1, 4'b0010, 7'h39);
    run_slot(2, 4'b0100, 7'h7C);
    run_slot(3, 4'b1000, 7'h77);

    // Frame 2: blank digit 2, blink digit 0 (blink phase is dark in frames 2-3).
    frame_no = 2;
    blank_mask = 4'b0100;
    blink_mask = 4'b0001;
    run_slot(0, BL_EN, BL_SEG);
    run_slot(1, 4'b0010, 7'h39);
    run_slot(2, 4'b0000, 7'h00);
    run_slot(3, 4'b1000, 7'h77);

    frame_no = 3;
    blank_mask = 4'b0000;
    run_slot(0, BL_EN, BL_SEG);
    run_slot(1, 4'b0010, 7'h39);
    run_slot(2, 4'b0100, 7'h7C);
    run_slot(3, 4'b1000, 7'h77);

    frame_no = 4;
    run_slot(0, 4'b0001, 7'h5E);
    run_slot(1, 4'b0010, 7'h39);
    run_slot(2, 4'b0100, 7'h7C);
    run_slot(3, 4'b1000, 7'h77);

    frame_no = 5;
    blink_mask = 4'b0000;
    run_slot(0, 4'b0001, 7'h5E);
    run_slot(1, 4'b0010, 7'h39);
    run_slot(2, 4'b0100, 7'h7C);
    run_slot(3, 4'b1000, 7'h77);

    // Frame 6: reset lands at slot 2, cnt=5.
    frame_no = 6;
    run_slot(0, 4'b0001, 7'h5E);
    run_slot(1, 4'b0010, 7'h39);
    run_slot(2, 4'b0100, 7'h7C, 5);
    chk("mid_s2_c5_en", {4'b0, en}, 8'h04);
    rst = 1'b1;
    digits = 16'h5678;
    @(negedge clk);
    chk("midrst_en", {4'b0, en}, 8'h00);
    chk("midrst_seg", {1'b0, m_disp}, 8'h00);
    chk("midrst_tick", {7'b0, frame_tick}, 8'h00);
    rst = 1'b0;

    frame_no = 7;
    run_slot(0, 4'b0001, 7'h7F);
    run_slot(1, 4'b0010, 7'h07);
    run_slot(2, 4'b0100, 7'h7D);
    run_slot(3, 4'b1000, 7'h6D);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the shared 4-digit 7-segment display on the detonator board. It takes four hex digit values plus per-digit blank and blink masks from the detonator core. It sequences the shared `m_disp` segment bus and the `en` digit-enable lines one digit at a time, inserting dead time between digits so neighbouring digits do not ghost. Inputs are sampled once per frame, so a mid-frame update never shows a torn display.

## Interface
- `SCAN_DIV`, 125000: clock cycles per digit slot (1 ms at 125 MHz); must be ≥ 2.
- `DEAD`, 1250: blank cycles at the start of each slot; 1 ≤ `DEAD` < `SCAN_DIV`.
- `BLINK_FRAMES`, 125: full frames per blink half-period; must be ≥ 1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `digits`  in  16  four hex nibbles; `digits[4k+3:4k]` drives digit k (k=0 is rightmost, `en[0]`).
- `blank_mask`  in  4  bit k=1 means digit k is always dark.
- `blink_mask`  in  4  bit k=1 means digit k blinks (see Configuration).
- `en`  out  4  one-hot digit enable, active-high; 0000 during dead time or when the digit is dark.
- `m_disp`  out  7  segments {g,f,e,d,c,b,a}, active-high.
- `frame_tick`  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- State:
  - slot counter `cnt`, 0..`SCAN_DIV`-1;
  - digit index `idx`, 0..3;
  - frame counter `fcnt`, 0..`BLINK_FRAMES`-1;
  - blink phase `ph`;
  - snapshot registers `s_dig[15:0]`, `s_blank[3:0]`, `s_blink[3:0]`.
- Slot and digit sequencing:
  - `cnt` increments every cycle.
  - At `SCAN_DIV`-1, `cnt` wraps to 0 and `idx` advances 0→1→2→3→0.
- Snapshot: on every edge where `idx`=0 and `cnt`=0, `s_dig`, `s_blank` and `s_blink` load from the inputs. This also happens on the first cycle after reset.
- Dead time: while `cnt` < `DEAD`, `en`=0000 and `m_disp`=0.
- Lit window (`cnt` ≥ `DEAD`):
  - The digit is dark if `s_blank[idx]`=1, or if `s_blink[idx]`=1 and `ph`=1.
  - A dark digit gives `en`=0000 and `m_disp`=0.
  - Otherwise `en`=1<<`idx` and `m_disp`=hex decode of `s_dig[4·idx+3:4·idx]`.
- Hex decode values:
  - digits 0–7: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07;
  - digits 8–F: 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Frame end:
  - `frame_tick`=1 exactly while `idx`=3 and `cnt`=`SCAN_DIV`-1.
  - On that edge `fcnt` increments.
  - When `fcnt` wraps from `BLINK_FRAMES`-1 to 0, `ph` toggles.
- Simultaneous events: a frame-end wrap and the snapshot load in the following cycle are independent; the new snapshot sees the new `ph`.
- Input changes have no visible effect until the next slot-0 snapshot. `blank_mask` takes priority over blink.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0, `fcnt`=0, `ph`=0, snapshots=0;
  - `en`=0000, `m_disp`=0000000, `frame_tick`=0.
- Reset mid-frame: all outputs are 0 on the cycle after the `rst` edge. The scan restarts at slot 0 and `cnt`=0, and re-snapshots on the first cycle after release.
- `en`, `m_disp` and `frame_tick` are registered.
  - Each equals the function above of the current state.
  - There is no combinational path from any input to any output.
- Latency:
  - An input change takes effect at cycle `DEAD` of the next slot 0.
  - Worst case is 4·`SCAN_DIV`+`DEAD` cycles.
- Frame period is 4·`SCAN_DIV` cycles. Blink period is 2·`BLINK_FRAMES` frames.
- `en` is never non-zero for two digits in the same cycle, and is never non-zero during dead time.

## Configuration
- `SEG_SCAN_BLINK_EN` defined: `fcnt` and `ph` exist, and blink works as described.
- `SEG_SCAN_BLINK_EN` undefined:
  - `fcnt`, `ph` and `s_blink` are not built.
  - `blink_mask` is ignored; digits are dark only via `blank_mask`.
  - `frame_tick` is unchanged.

## Test plan
All scenarios use `SCAN_DIV`=8, `DEAD`=2, `BLINK_FRAMES`=2, `digits`=16'h1234, masks=0 unless stated.
- Reset: hold `rst` 3 cycles → `en`=0000, `m_disp`=00, `frame_tick`=0. After release: cycles 0–1 blank; cycles 2–7 give `en`=0001, `m_disp`=66.
- Scan order → the bench must see, with every slot having 2 blank cycles then 6 lit cycles:
  - `en`=0001/66;
  - `en`=0010/4F;
  - `en`=0100/5B;
  - `en`=1000/06;
  - `frame_tick` pulse every 32 cycles, on cycle 31 of each frame.
- Tearing: change `digits` to 16'hABCD during slot 1 → slots 1–3 still show 3, 2, 1. The next frame shows D(5E), C(39), b(7C), A(77).
- Blank: `blank_mask`=0100 → `en`=0000 and `m_disp`=00 for all of slot 2. Other slots are unaffected.
- Blink (macro defined): `blink_mask`=0001 → digit 0 lit in frames 0–1, dark in frames 2–3, lit in frames 4–5.
- Blink (macro undefined): digit 0 is always lit.
- Reset mid-operation: assert `rst` at slot 2, `cnt`=5 → outputs 0 next cycle. After release the scan restarts at slot 0 with a fresh snapshot.
